axis_sample_packer: RTL and testbench

AXIS_SAMPLE_PACKER -- requirements
Module: axis_sample_packer

---
 rtl/axis_sample_packer_if.sv | 21 ++
 rtl/axis_sample_packer.sv | 132 +++++++++++++
 tb/tb_axis_sample_packer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_sample_packer_if.sv
// AXI-stream style handshake bundle (tdata/tvalid/tready) of configurable width.
// The packer uses it for its 16-bit sample input and its 32-bit word output.
interface axis_sample_packer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axis_sample_packer.sv
// Packs pairs of 16-bit samples into 32-bit words (first sample in the low half)
// and buffers them in a first-word-fall-through FIFO with sticky overflow.
module axis_sample_packer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_sample_packer_if.slave   s_axis,
  axis_sample_packer_if.master  m_axis,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   word_count,
  output logic                  overflow,
  input  logic                  overflow_clear
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  localparam logic [0:0] ST_LOW  = 1'b0;
  localparam logic [0:0] ST_HIGH = 1'b1;

  logic [0:0]            state_reg, state_next;
  logic [15:0]           holding_reg, holding_next;
  logic                  tready_reg;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  overflow_reg, overflow_next;

  logic [31:0] mem [DEPTH];

  logic        sample_xfer;
  logic        word_formed;
  logic [31:0] formed_word;
  logic        rd_fire;
  logic        fifo_full;
  logic        wr_fire;
  logic        drop;

  assign sample_xfer = s_axis.tvalid & tready_reg;
  assign word_formed = sample_xfer & (state_reg == ST_HIGH);
  assign formed_word = {s_axis.tdata, holding_reg};

  assign m_axis.tvalid = (count_reg != '0);
  assign m_axis.tdata  = mem[rd_ptr_reg];
  assign rd_fire       = m_axis.tvalid & m_axis.tready;

  // A full FIFO still takes the new word when the head leaves in the same cycle.
  assign fifo_full = (count_reg == FULL_COUNT);
  assign wr_fire   = word_formed & (~fifo_full | rd_fire) & ~flush;
  assign drop      = word_formed & fifo_full & ~rd_fire & ~flush;

  assign s_axis.tready = tready_reg;
  assign word_count    = count_reg;
  assign overflow      = overflow_reg;

  always_comb begin
    state_next    = state_reg;
    holding_next  = holding_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;

    if (flush) begin
      state_next  = ST_LOW;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (sample_xfer) begin
        if (state_reg == ST_LOW) begin
          holding_next = s_axis.tdata;
          state_next   = ST_HIGH;
        end else begin
          state_next   = ST_LOW;
        end
      end

      if (wr_fire) begin
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end
      if (rd_fire) begin
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end

      case ({wr_fire, rd_fire})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  // A drop in the same cycle as a clear request wins, so no loss goes unreported.
  always_comb begin
    overflow_next = overflow_reg;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (overflow_clear) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg    <= ST_LOW;
      holding_reg  <= '0;
      tready_reg   <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      holding_reg  <= holding_next;
      tready_reg   <= ~flush;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= formed_word;
    end
  end

endmodule

// File: tb/tb_axis_sample_packer.sv
// Self-checking bench for axis_sample_packer: a vector table, hand-written corner
// sequences and randomized traffic, all compared against a queue-based reference model.
module tb_axis_sample_packer;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic                aclk = 1'b0;
  logic                aresetn = 1'b0;
  logic                flush = 1'b0;
  logic                overflow_clear = 1'b0;
  logic [DEPTH_LOG2:0] word_count;
  logic                overflow;

  axis_sample_packer_if #(.WIDTH(16)) s_if ();
  axis_sample_packer_if #(.WIDTH(32)) m_if ();

  always #5 aclk = ~aclk;

  axis_sample_packer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .flush          (flush),
    .word_count     (word_count),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: list of buffered words plus an optional pending half-word.
  bit          mdl_ready = 1'b0;
  bit          half_valid = 1'b0;
  logic [15:0] half_val = '0;
  logic [31:0] q[$];
  bit          mdl_ovf = 1'b0;
  int          words_formed = 0;

  typedef struct {
    bit          v;
    logic [15:0] d;
    bit          mr;
    bit          fl;
    bit          clr;
    bit          e_rdy;
    bit          e_tv;
    logic [31:0] e_td;
    logic [4:0]  e_cnt;
    bit          e_ovf;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit mr, input bit fl, input bit clr);
    s_if.tvalid    = v;
    s_if.tdata     = d;
    m_if.tready    = mr;
    flush          = fl;
    overflow_clear = clr;
  endtask

  task automatic model_step();
    bit          xfer;
    bit          rd;
    bit          formed;
    bit          dropped;
    logic [31:0] w;
    xfer = s_if.tvalid && mdl_ready;
    rd   = (q.size() != 0) && m_if.tready;
    if (!aresetn) begin
      q.delete();
      half_valid = 1'b0;
      half_val   = '0;
      mdl_ovf    = 1'b0;
      mdl_ready  = 1'b0;
      return;
    end
    formed = xfer && half_valid;
    w      = {s_if.tdata, half_val};
    if (flush) begin
      q.delete();
      half_valid = 1'b0;
      mdl_ready  = 1'b0;
      if (overflow_clear) mdl_ovf = 1'b0;
      return;
    end
    mdl_ready = 1'b1;
    dropped   = formed && (q.size() >= DEPTH) && !rd;
    if (dropped) mdl_ovf = 1'b1;
    else if (overflow_clear) mdl_ovf = 1'b0;
    if (rd) void'(q.pop_front());
    if (formed && !dropped) begin
      q.push_back(w);
      words_formed++;
    end
    if (xfer) begin
      if (half_valid) begin
        half_valid = 1'b0;
      end else begin
        half_val   = s_if.tdata;
        half_valid = 1'b1;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_tready"}, 32'(s_if.tready), 32'(mdl_ready));
    check({tag, "_tvalid"}, 32'(m_if.tvalid), 32'(q.size() != 0));
    check({tag, "_count"}, 32'(word_count), 32'(q.size()));
    check({tag, "_ovf"}, 32'(overflow), 32'(mdl_ovf));
    if (q.size() != 0) check({tag, "_tdata"}, m_if.tdata, q[0]);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge aclk);
    #1;
    compare_model(tag);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0};
    tbl[1]  = '{1'b1, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22221111, 5'd1, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0};
    tbl[3]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0};
    tbl[4]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00020001, 5'd1, 1'b0};
    tbl[5]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00020001, 5'd1, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0};
    tbl[7]  = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0};
    tbl[8]  = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0};
    tbl[9]  = '{1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hBBBBAAAA, 5'd1, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0};

    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b0;
    repeat (3) cycle("reset");
    check("rst_tready", 32'(s_if.tready), 32'd0);
    check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    aresetn = 1'b1;
    cycle("release");
    check("release_tready", 32'(s_if.tready), 32'd1);

    // Basic packing and flush mid-pair from the vector table
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].mr, tbl[i].fl, tbl[i].clr);
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_exp_tready", i), 32'(s_if.tready), 32'(tbl[i].e_rdy));
      check($sformatf("vec%0d_exp_tvalid", i), 32'(m_if.tvalid), 32'(tbl[i].e_tv));
      check($sformatf("vec%0d_exp_count", i), 32'(word_count), 32'(tbl[i].e_cnt));
      check($sformatf("vec%0d_exp_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
      if (tbl[i].e_tv) check($sformatf("vec%0d_exp_tdata", i), m_if.tdata, tbl[i].e_td);
    end

    // Fill to full, overflow on the 17th word, then drain words 1..16
    for (int i = 1; i <= 34; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      cycle("fill");
      if (i == 32) begin
        check("fill32_count", 32'(word_count), 32'd16);
        check("fill32_ovf", 32'(overflow), 32'd0);
      end
    end
    check("fill34_count", 32'(word_count), 32'd16);
    check("fill34_ovf", 32'(overflow), 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("drain%0d_tvalid", k), 32'(m_if.tvalid), 32'd1);
      check($sformatf("drain%0d_tdata", k), m_if.tdata, {16'(2 * k), 16'(2 * k - 1)});
      cycle("drain");
    end
    check("drained_count", 32'(word_count), 32'd0);
    check("drained_tvalid", 32'(m_if.tvalid), 32'd0);
    check("drained_ovf_sticky", 32'(overflow), 32'd1);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    cycle("clr");
    check("clr_ovf", 32'(overflow), 32'd0);

    // Full FIFO with a simultaneous read accepts the new word
    for (int i = 1; i <= 33; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
      cycle("full");
    end
    check("full_count", 32'(word_count), 32'd16);
    drive(1'b1, 16'h0122, 1'b1, 1'b0, 1'b0);
    cycle("full_rw");
    check("full_rw_count", 32'(word_count), 32'd16);
    check("full_rw_ovf", 32'(overflow), 32'd0);
    check("full_rw_head", m_if.tdata, 32'h01040103);
    // Drop coinciding with overflow_clear leaves overflow set
    drive(1'b1, 16'h0123, 1'b0, 1'b0, 1'b0);
    cycle("drop_a");
    drive(1'b1, 16'h0124, 1'b0, 1'b0, 1'b1);
    cycle("drop_b");
    check("drop_clr_ovf", 32'(overflow), 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    cycle("flush");
    check("flush_count", 32'(word_count), 32'd0);
    check("flush_ovf_kept", 32'(overflow), 32'd1);
    check("flush_tready", 32'(s_if.tready), 32'd0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    cycle("clr2");
    check("clr2_ovf", 32'(overflow), 32'd0);

    // Reset mid-stream with five words and a half-word buffered
    for (int i = 1; i <= 11; i++) begin
      drive(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
      cycle("pre_rst");
    end
    check("pre_rst_count", 32'(word_count), 32'd5);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b0;
    cycle("mid_rst");
    check("mid_rst_tready", 32'(s_if.tready), 32'd0);
    check("mid_rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("mid_rst_count", 32'(word_count), 32'd0);
    cycle("mid_rst2");
    aresetn = 1'b1;
    cycle("mid_rel");
    drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    cycle("post_rst_a");
    drive(1'b1, 16'h5678, 1'b0, 1'b0, 1'b0);
    cycle("post_rst_b");
    check("post_rst_word", m_if.tdata, 32'h56781234);
    check("post_rst_count", 32'(word_count), 32'd1);

    // Continuous samples with random backpressure, at least 100 words
    words_formed = 0;
    for (int c = 0; c < 2000 && words_formed < 100; c++) begin
      drive(1'b1, 16'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
      cycle("stream");
    end
    check("stream_words", 32'(words_formed >= 100), 32'd1);

    // Fully random traffic including occasional flush and clear pulses
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0));
      cycle("rand");
    end

    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    repeat (20) cycle("final_drain");
    check("final_count", 32'(word_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
